instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage feeding the main/ALU decoder: holds the program counter, fetches 32-bit words from instruction memory over a request/acknowledge handshake, and presents the held instruction (with its `op` and `funct` fields pre-split) to decode under a valid/ready handshake. It computes the next PC internally from the held instruction and the `branch`, `zero` and `jump` results returned by control/execute. Sequential: PC register, instruction register, 2-state FSM, retired-instruction counter.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset; must be word-aligned.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the fetch; equals PC.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `instr`  out  32  held instruction.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr`/`op`/`funct`/`pc_plus4` valid for decode.
- `instr_ready`  in  1  decode/execute consumes the held instruction this cycle.
- `branch`  in  1  held instruction is a taken-candidate branch (from control).
- `zero`  in  1  ALU zero flag for the held instruction.
- `jump`  in  1  held instruction is a jump (from control).
- `pc`  out  32  PC of the held/being-fetched instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `retired`  out  32  count of consumed instructions.

## Operation
- FSM states: FETCH, HOLD. Reset → FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, `instr_valid`=0. On `imem_ack`=1: `instr` ← `imem_rdata`, go HOLD.
- HOLD: `imem_req`=0, `instr_valid`=1. `branch`/`zero`/`jump` sampled only when `instr_ready`=1; otherwise ignored. On `instr_ready`=1: `pc` ← next PC, `retired` ← `retired`+1, go FETCH. Without `instr_ready`, all held outputs stay stable.
- Next PC priority: `jump` → `{pc_plus4[31:28], instr[25:0], 2'b00}`; else `branch & zero` → `pc_plus4 + (sign_extend(instr[15:0]) << 2)`; else `pc_plus4`.
- Arithmetic 32-bit, wraps modulo 2^32 (PC 32'hFFFF_FFFC + 4 → 0). `retired` wraps FFFF_FFFF → 0.
- `pc[1:0]` always 00 given aligned `RESET_PC`; no alignment checking.
- `op`, `funct` purely combinational slices of `instr`.
- `imem_ack` while in HOLD is ignored; `imem_rdata` not captured.
- Reset values: state FETCH, `pc`=`RESET_PC`, `instr`=0, `retired`=0; hence `op`=0, `funct`=0, `instr_valid`=0, `pc_plus4`=`RESET_PC`+4, `imem_addr`=`RESET_PC`. `imem_req`=0 while `rst`=1, 1 in first cycle after release.

## Timing
- `imem_ack` may assert in the same cycle `imem_req` rises (minimum memory latency 1 cycle); any number of wait cycles allowed; `imem_addr` held stable until ack.
- Capture at the edge with `imem_ack`=1; `instr_valid`=1 from the next cycle.
- Consume at the edge with `instr_valid & instr_ready`; `imem_req`=1 with new PC from the next cycle.
- Peak throughput: one instruction per 2 cycles (ack and ready both immediate).
- `rst` asserted mid-fetch or mid-hold: all state clears immediately (asynchronous), pending fetch abandoned, any `imem_ack` during reset ignored; fetch restarts at `RESET_PC`.

## Test plan
- Reset, `imem_ack` tied 1, `instr_ready` tied 1, sequential R-type words → `imem_addr` 0,4,8,C on every other cycle; `retired` increments each consume; `op`=0, `funct` matches words.
- Wait states: ack delayed 3 cycles, ready delayed 2 cycles → `imem_addr` stable over wait, `instr` stable over stall, no double count in `retired`.
- Branch at PC 0x10, imm 16'hFFFE, `branch`=1, `zero`=1 → next fetch 0x0C; same with `zero`=0 → 0x14.
- Jump at PC 0x1000_0000, `instr[25:0]`=26'h0000040 → next fetch 0x1000_0100; `jump`=1 overrides simultaneous `branch&zero`.
- Wrap: `RESET_PC`=32'hFFFF_FFFC, sequential consume → next fetch 0x0000_0000; stray ack during HOLD ignored.
- Assert `rst` during a pending fetch with ack arriving same cycle → `instr`=0, `instr_valid`=0, `retired`=0, refetch from `RESET_PC` after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// presents the held word to decode under valid/ready, computing the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t      state, state_nxt;
    logic        capture, consume;
    logic [31:0] pc_nxt, br_off, jmp_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        consume     = 1'b0;
        case (state)
            FETCH: begin
                // Request is masked by reset so nothing is issued while held in reset.
                imem_req = ~rst;
                if (imem_ack) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    consume   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jmp_tgt   = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        pc_nxt = pc_plus4;
        if (jump)                pc_nxt = jmp_tgt;
        else if (branch && zero) pc_nxt = pc_plus4 + br_off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            if (capture) instr <= imem_rdata;
            if (consume) begin
                pc      <= pc_nxt;
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// handshakes checked against a transaction-level reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, imem_ack, instr_ready, branch, zero, jump;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired;
    logic [5:0]  op, funct;

    // Auxiliary instances with non-zero reset PCs share one set of inputs.
    logic        a_rst, a_ack, a_ready, a_branch, a_zero, a_jump;
    logic [31:0] a_rdata;
    logic        wa_req, wa_valid, wb_req, wb_valid;
    logic [31:0] wa_addr, wa_instr, wa_pc, wa_p4, wa_ret;
    logic [31:0] wb_addr, wb_instr, wb_pc, wb_p4, wb_ret;
    logic [5:0]  wa_op, wa_funct, wb_op, wb_funct;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_hold;
    logic [31:0] m_pc, m_instr, m_ret;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op(op),
        .funct(funct), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch(branch), .zero(zero), .jump(jump), .pc(pc),
        .pc_plus4(pc_plus4), .retired(retired)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(a_rst), .imem_req(wa_req), .imem_addr(wa_addr),
        .imem_ack(a_ack), .imem_rdata(a_rdata), .instr(wa_instr), .op(wa_op),
        .funct(wa_funct), .instr_valid(wa_valid), .instr_ready(a_ready),
        .branch(a_branch), .zero(a_zero), .jump(a_jump), .pc(wa_pc),
        .pc_plus4(wa_p4), .retired(wa_ret)
    );

    instr_fetch_unit #(.RESET_PC(32'h1000_0000)) dut_high (
        .clk(clk), .rst(a_rst), .imem_req(wb_req), .imem_addr(wb_addr),
        .imem_ack(a_ack), .imem_rdata(a_rdata), .instr(wb_instr), .op(wb_op),
        .funct(wb_funct), .instr_valid(wb_valid), .instr_ready(a_ready),
        .branch(a_branch), .zero(a_zero), .jump(a_jump), .pc(wb_pc),
        .pc_plus4(wb_p4), .retired(wb_ret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                             input bit br, input bit z, input bit j);
        logic [31:0] seq;
        int          off;
        seq = cur_pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        if (br && z) begin
            off = int'(ins & 32'h0000_FFFF);
            if (off >= 32768) off = off - 65536;
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic compare_all();
        check("imem_req",    32'(imem_req),    32'(!m_hold));
        check("instr_valid", 32'(instr_valid), 32'(m_hold));
        check("imem_addr",   imem_addr, m_pc);
        check("pc",          pc,        m_pc);
        check("pc_plus4",    pc_plus4,  m_pc + 32'd4);
        check("instr",       instr,     m_instr);
        check("op",          32'(op),    m_instr >> 26);
        check("funct",       32'(funct), m_instr % 64);
        check("retired",     retired,   m_ret);
    endtask

    task automatic step(input bit ack, input logic [31:0] rd, input bit rdy,
                        input bit br, input bit z, input bit j);
        imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
        branch = br; zero = z; jump = j;
        if (!m_hold) begin
            if (ack) begin
                m_instr = rd;
                m_hold  = 1'b1;
            end
        end else if (rdy) begin
            m_pc   = ref_next(m_pc, m_instr, br, z, j);
            m_ret  = m_ret + 32'd1;
            m_hold = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Reset asserted with an ack pending; state must clear at once and the ack be dropped.
    task automatic do_reset();
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; instr_ready = 1'b1;
        rst = 1'b1;
        m_hold = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_ret = 32'h0;
        #1;
        check("rst_instr",   instr, 32'h0);
        check("rst_valid",   32'(instr_valid), 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_req",     32'(imem_req), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_instr", instr, 32'h0);
        check("rst_hold_req",   32'(imem_req), 32'h0);
        rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        #1;
        compare_all();
    endtask

    task automatic aux_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0;
        a_rst = 1'b1; a_ack = 1'b0; a_rdata = '0; a_ready = 1'b0;
        a_branch = 1'b0; a_zero = 1'b0; a_jump = 1'b0;
        @(negedge clk);
        do_reset();

        // Back-to-back R-type words, ack and ready immediate.
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", imem_addr, 32'(i * 4));
            step(1'b1, 32'h0000_0020 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("seq_retired", retired, 32'd4);

        // Taken branch at 0x10 back by one word, then not-taken.
        step(1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("br_taken", imem_addr, 32'h0000_000C);
        step(1'b1, 32'h0000_0025, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("br_not_taken", imem_addr, 32'h0000_0014);

        // Memory wait states and decode stalls with garbage control inputs.
        for (int i = 0; i < 3; i++) step(1'b0, 32'hBAD0_0000, 1'b0, 1'b1, 1'b1, 1'b1);
        check("wait_addr", imem_addr, 32'h0000_0014);
        step(1'b1, 32'h0123_4567, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 1'b1, 1'b1);
        check("stall_instr", instr, 32'h0123_4567);
        check("stall_retired", retired, 32'd7);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stall_one_count", retired, 32'd8);

        // Jump beats a simultaneous taken branch.
        step(1'b1, 32'h0800_0040, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("jump_over_br", imem_addr, 32'h0000_0100);

        do_reset();

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) == 0, $urandom, ($urandom % 2) == 0,
                 ($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 5) == 0);
            if (i == 300) begin
                step(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
                do_reset();
            end
        end

        // Wrap and high-region jump on the auxiliary instances.
        @(negedge clk);
        a_rst = 1'b0;
        #1;
        check("wrap_reset_addr", wa_addr, 32'hFFFF_FFFC);
        check("wrap_reset_p4",   wa_p4,   32'h0000_0000);
        check("high_reset_addr", wb_addr, 32'h1000_0000);
        check("aux_req",         32'(wa_req), 32'h1);
        a_ack = 1'b1; a_rdata = 32'h0800_0040;
        aux_step();
        check("aux_valid", 32'(wa_valid), 32'h1);
        a_rdata = 32'hDEAD_BEEF;
        aux_step();
        check("stray_ack_instr", wa_instr, 32'h0800_0040);
        check("stray_ack_valid", 32'(wb_valid), 32'h1);
        a_ack = 1'b0; a_ready = 1'b1; a_jump = 1'b1; a_branch = 1'b1; a_zero = 1'b1;
        aux_step();
        a_ready = 1'b0; a_jump = 1'b0; a_branch = 1'b0; a_zero = 1'b0;
        check("high_jump", wb_addr, 32'h1000_0100);
        check("wrap_jump", wa_addr, 32'h0000_0100);
        check("high_retired", wb_ret, 32'd1);

        a_rst = 1'b1;
        #1;
        a_rst = 1'b0;
        a_ack = 1'b1; a_rdata = 32'h0000_0020;
        aux_step();
        a_ack = 1'b0; a_ready = 1'b1;
        aux_step();
        a_ready = 1'b0;
        check("wrap_seq",  wa_addr, 32'h0000_0000);
        check("wrap_p4",   wa_p4,   32'h0000_0004);
        check("high_seq",  wb_addr, 32'h1000_0004);
        check("wrap_ret",  wa_ret,  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
